// File: rtl/fft_pkg.sv
// Shared types and constants for the 16-point radix-2 FFT sequencer.
package fft_pkg;

  localparam int N_POINTS = 16;
  localparam int N_STAGES = 4;
  localparam int TW_W     = 32;
  localparam int N_BFLY   = N_POINTS / 2;

  typedef logic [TW_W-1:0] twiddle_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STAGE = 2'd2,
    HOLD  = 2'd3
  } fft_seq_state_e;

  // W16^e = cos(2*pi*e/16) - j*sin(2*pi*e/16), {re, im} in Q1.15
  localparam twiddle_t W16_ROM [N_BFLY] = '{
    32'h7FFF_0000, 32'h7642_CF04, 32'h5A82_A57E, 32'h30FC_89BE,
    32'h0000_8000, 32'hCF04_89BE, 32'hA57E_A57E, 32'h89BE_CF04
  };

  // e = (k >> (3-s)) << (3-s): keep the top s bits of k
  function automatic logic [2:0] tw_exp(input logic [1:0] s, input logic [2:0] k);
    logic [2:0] e;
    case (s)
      2'd0:    e = 3'd0;
      2'd1:    e = {k[2], 2'b00};
      2'd2:    e = {k[2:1], 1'b0};
      default: e = k;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/fft_twiddle_rom.sv
// Per-butterfly twiddle lookup: (stage, K) -> W16^e, zero when not enabled.
module fft_twiddle_rom
  import fft_pkg::*;
#(
  parameter int K = 0
) (
  input  logic [1:0] stage,
  input  logic       en,
  output twiddle_t   tw
);

  localparam logic [2:0] KIDX = 3'(K);

  assign tw = en ? W16_ROM[tw_exp(stage, KIDX)] : '0;

endmodule

// File: rtl/fft_sequencer.sv
// Control FSM for the 16-point FFT datapath: load, 4 butterfly stages, hold.
// Optional drop counter enabled by defining FFT_SEQ_DROP_CNT_EN.
module fft_sequencer
  import fft_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_strobe,
  output logic                   load,
  output logic                   stage_en,
  output logic [1:0]             stage,
  output logic [N_BFLY*TW_W-1:0] tw_bus,
  output logic                   busy,
  output logic                   result_valid,
  input  logic                   result_ready
`ifdef FFT_SEQ_DROP_CNT_EN
  ,
  output logic [15:0]            drop_count
`endif
);

  localparam logic [1:0] LAST_STAGE = 2'(N_STAGES - 1);

  fft_seq_state_e state, state_nxt;
  logic [1:0]     stage_q, stage_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      stage_q <= '0;
    end else begin
      state   <= state_nxt;
      stage_q <= stage_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    stage_nxt = stage_q;
    case (state)
      IDLE: begin
        stage_nxt = '0;
        if (frame_strobe) state_nxt = LOAD;
      end
      LOAD: begin
        stage_nxt = '0;
        state_nxt = STAGE;
      end
      STAGE: begin
        if (stage_q == LAST_STAGE) begin
          stage_nxt = '0;
          state_nxt = HOLD;
        end else begin
          stage_nxt = stage_q + 2'd1;
        end
      end
      HOLD: begin
        if (result_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are pure decodes of registered state
  assign load         = (state == LOAD);
  assign stage_en     = (state == STAGE);
  assign stage        = stage_en ? stage_q : 2'd0;
  assign busy         = (state == LOAD) || (state == STAGE);
  assign result_valid = (state == HOLD);

  logic [N_BFLY-1:0][TW_W-1:0] tw_lane;

  for (genvar k = 0; k < N_BFLY; k++) begin : g_tw
    fft_twiddle_rom #(.K(k)) u_rom (
      .stage (stage_q),
      .en    (stage_en),
      .tw    (tw_lane[k])
    );
  end

  assign tw_bus = tw_lane;

`ifdef FFT_SEQ_DROP_CNT_EN
  logic        drop;
  logic [15:0] drop_q;

  assign drop = frame_strobe && (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             drop_q <= '0;
    else if (drop && (drop_q != 16'hFFFF))  drop_q <= drop_q + 16'd1;
  end

  assign drop_count = drop_q;
`endif

endmodule
